symbol_generator: RTL and testbench
===================================

// Module: symbol_generator
// PURPOSE
//  Producer side of the game-period symbol stream. Reacts to startGen/stopGen from the game-period block.
//  Emits a pseudo-random sequence of 7-seg symbols, one per symGenMax Clk100M cycles, separated by blank gaps.
//  Counts the magic symbols it shows; Score compares magicSymbolCount against the player's userCount.
// PARAMETERS
//  NUM_SYMBOLS  6        distinct symbol codes, legal range 4..8
//  MAGIC_CODE   3'd0     symbol code that is counted; must be < NUM_SYMBOLS
//  GAP_CYCLES   32'd2    blank cycles between symbols; must be >= 1
//  SEED         16'hACE1 base LFSR seed; must be nonzero
// PORTS
//  Clk100M          in   1   system clock, all logic on rising edge
//  reset            in   1   asynchronous, active-low reset
//  startGen         in   1   1-cycle pulse: begin a new sequence
//  stopGen          in   1   1-cycle pulse: end the sequence
//  symGenMax        in   32  cycles each symbol is displayed; 0 is treated as 1
//  curLevel         in   4   current level, mixed into the seed
//  genActive        out  1   high while a sequence runs (LOAD/SHOW/GAP)
//  symValid         out  1   1-cycle pulse when a new symbol appears
//  symCode          out  3   code of the displayed symbol
//  symSeg           out  8   active-low segments {dp,g,f,e,d,c,b,a}; 8'hFF is blank
//  magicSymbolCount out  8   magic symbols shown this sequence, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, genActive=0, symValid=0, symCode=0,
//   symSeg=8'hFF, magicSymbolCount=0, lfsr=SEED.
//  States and transitions:
//   IDLE: on startGen (and no stopGen that cycle) -> LOAD.
//   LOAD (1 cycle): lfsr <= SEED^{12'b0,curLevel}, or SEED if that value is 0; count <= 0 -> SHOW.
//   SHOW: show the symbol for max(symGenMax,1) cycles, then -> GAP.
//   GAP: symSeg=8'hFF for GAP_CYCLES cycles, then -> SHOW.
//  Entry to SHOW, at the same edge:
//   - step the LFSR once;
//   - code = lfsr[2:0], or lfsr[2:0]-NUM_SYMBOLS if lfsr[2:0] >= NUM_SYMBOLS;
//   - drive symCode/symSeg from the code and pulse symValid for 1 cycle;
//   - if code==MAGIC_CODE and count != 255, increment count.
//  Latency: startGen sampled at edge k. LOAD is active after edge k. First symValid and first symSeg
//   are valid after edge k+2. Symbol period is max(symGenMax,1)+GAP_CYCLES cycles.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts left; new bit = b15^b13^b12^b10.
//  Timer: one 32-bit down-counter, reloaded on every state entry.
//  Boundary conditions:
//   - stopGen in any active state: -> IDLE next edge; symSeg=8'hFF, symValid=0, genActive=0.
//     magicSymbolCount holds its value until the next LOAD.
//   - stopGen and startGen in the same cycle: stopGen wins; from IDLE, stay in IDLE.
//   - startGen while active: restart via LOAD (reseed and clear the count).
//   - stopGen in IDLE: ignored.
//   - symGenMax changing mid-sequence: takes effect at the next SHOW entry only.
//   - reset mid-sequence: immediate return to the reset values.
// STRUCTURE
//  Package sym_pkg:
//   - state enum {IDLE,LOAD,SHOW,GAP};
//   - SYM_SEG[0:7] 7-seg pattern table;
//   - SEG_BLANK=8'hFF;
//   - LFSR tap constant.
//  Sub-module lfsr16 (load, step, seed, out[15:0]).
//  FSM, timer, code mapping and counter stay in symbol_generator.
// TESTING
//  1 Reset low mid-SHOW -> all outputs at reset values within the same cycle; after release, IDLE.
//  2 symGenMax=4, GAP_CYCLES=2, curLevel=1, start -> first symValid 2 cycles later, then every 6 cycles;
//    codes match a software LFSR model seeded 16'hACE0.
//  3 Run 50 symbols then stopGen -> blank next cycle, genActive=0;
//    magicSymbolCount equals the model's magic count and is held.
//  4 startGen+stopGen in the same cycle from IDLE -> stays IDLE, no symValid for 20 cycles.
//  5 symGenMax=0 -> treated as 1: symValid every 1+GAP_CYCLES=3 cycles.
//  6 NUM_SYMBOLS=4, symGenMax=1, 1500 symbols -> magicSymbolCount saturates at 255 and never wraps.

Source files
------------

// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sym_pkg
//  Description : Shared types and constants for the game-period symbol
//                generator: FSM state encoding, 7-segment pattern table,
//                blank pattern and the LFSR feedback taps / step helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_pkg;

    // Generator sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Active-low segment pattern for a dark display, {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low 7-segment glyphs for symbol codes 0..7 (digits 0..7)
    localparam logic [7:0] SYM_SEG [0:7] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8
    };

    // Feedback taps of x^16+x^14+x^13+x^11+1 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One left shift of the Fibonacci LFSR; the XOR of the tapped bits enters at bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/symbol_generator_if.sv
`default_nettype none
// ============================================================================
//  Interface   : symbol_generator_if
//  Description : Control and symbol-stream signals between the game-period
//                block (master) and the symbol generator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface symbol_generator_if;

    logic        startGen;
    logic        stopGen;
    logic [31:0] symGenMax;
    logic [3:0]  curLevel;
    logic        genActive;
    logic        symValid;
    logic [2:0]  symCode;
    logic [7:0]  symSeg;
    logic [7:0]  magicSymbolCount;

    // Game-period side: issues start/stop and timing, observes the stream
    modport master (
        output startGen, stopGen, symGenMax, curLevel,
        input  genActive, symValid, symCode, symSeg, magicSymbolCount
    );

    // Generator side
    modport slave (
        input  startGen, stopGen, symGenMax, curLevel,
        output genActive, symValid, symCode, symSeg, magicSymbolCount
    );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR with synchronous load and step.
//                Load has priority over step.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import sym_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  wire logic        Clk100M,
    input  wire logic        reset,
    input  wire logic        load,
    input  wire logic        step,
    input  wire logic [15:0] seed,
    output logic      [15:0] out
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    // Next value: reseed, advance one step, or hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Shift register with asynchronous active-low reset to the base seed
    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/symbol_generator.sv
`default_nettype none
// ============================================================================
//  Module      : symbol_generator
//  Description : Producer of the game-period symbol stream. After startGen
//                it reseeds an LFSR from the level, then alternates between
//                showing a pseudo-random 7-seg symbol and a blank gap,
//                counting how many magic symbols were shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module symbol_generator
    import sym_pkg::*;
#(
    parameter int unsigned NUM_SYMBOLS = 6,
    parameter logic [2:0]  MAGIC_CODE  = 3'd0,
    parameter logic [31:0] GAP_CYCLES  = 32'd2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  wire logic         Clk100M,
    input  wire logic         reset,
    symbol_generator_if.slave bus
);

    localparam logic [3:0] NUM_SYM = 4'(NUM_SYMBOLS);

    state_e      state_d,      state_q;
    logic [31:0] timer_d,      timer_q;
    logic        show_pend_d,  show_pend_q;
    logic        gap_pend_d,   gap_pend_q;
    logic        gen_active_d, gen_active_q;
    logic        sym_valid_d,  sym_valid_q;
    logic [2:0]  sym_code_d,   sym_code_q;
    logic [7:0]  sym_seg_d,    sym_seg_q;
    logic [7:0]  count_d,      count_q;

    logic        lfsr_load;
    logic        lfsr_step_en;
    logic [15:0] lfsr_out;
    logic [15:0] seed_mix;
    logic [15:0] lfsr_seed;
    logic [31:0] show_len;
    logic [2:0]  raw_code;
    logic [2:0]  next_code;

    lfsr16 #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .Clk100M (Clk100M),
        .reset   (reset),
        .load    (lfsr_load),
        .step    (lfsr_step_en),
        .seed    (lfsr_seed),
        .out     (lfsr_out)
    );

    // Seed, display length and the code that the next LFSR step will produce
    always_comb begin
        seed_mix  = SEED ^ {12'b0, bus.curLevel};
        lfsr_seed = (seed_mix == 16'd0) ? SEED : seed_mix;
        show_len  = (bus.symGenMax == 32'd0) ? 32'd1 : bus.symGenMax;
        // Low three bits of the stepped value, without building the full word
        raw_code  = {lfsr_out[1:0], ^(lfsr_out & LFSR_TAPS)};
        if ({1'b0, raw_code} >= NUM_SYM) begin
            next_code = raw_code - NUM_SYM[2:0];
        end else begin
            next_code = raw_code;
        end
    end

    // Sequencer and display stage. The display trails the state by one
    // cycle: the LFSR is only reseeded on the edge that enters SHOW, so the
    // symbol is stepped and shown on the following edge. SHOW and GAP thus
    // keep their lengths, shifted by one cycle on the outputs.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        show_pend_d  = show_pend_q;
        gap_pend_d   = gap_pend_q;
        gen_active_d = gen_active_q;
        sym_valid_d  = 1'b0;
        sym_code_d   = sym_code_q;
        sym_seg_d    = sym_seg_q;
        count_d      = count_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.startGen && !bus.stopGen) begin
                    state_d      = LOAD;
                    timer_d      = 32'd0;
                    gen_active_d = 1'b1;
                end
            end
            default: begin
                if (bus.stopGen) begin
                    state_d      = IDLE;
                    timer_d      = 32'd0;
                    gen_active_d = 1'b0;
                    sym_seg_d    = SEG_BLANK;
                    show_pend_d  = 1'b0;
                    gap_pend_d   = 1'b0;
                end else if (bus.startGen) begin
                    state_d      = LOAD;
                    timer_d      = 32'd0;
                    sym_seg_d    = SEG_BLANK;
                    show_pend_d  = 1'b0;
                    gap_pend_d   = 1'b0;
                end else begin
                    if (show_pend_q) begin
                        lfsr_step_en = 1'b1;
                        sym_code_d   = next_code;
                        sym_seg_d    = SYM_SEG[next_code];
                        sym_valid_d  = 1'b1;
                        show_pend_d  = 1'b0;
                        if ((next_code == MAGIC_CODE) && (count_q != 8'hFF)) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                    if (gap_pend_q) begin
                        sym_seg_d  = SEG_BLANK;
                        gap_pend_d = 1'b0;
                    end
                    case (state_q)
                        LOAD: begin
                            lfsr_load   = 1'b1;
                            count_d     = 8'd0;
                            state_d     = SHOW;
                            timer_d     = show_len - 32'd1;
                            show_pend_d = 1'b1;
                        end
                        SHOW: begin
                            if (timer_q == 32'd0) begin
                                state_d    = GAP;
                                timer_d    = GAP_CYCLES - 32'd1;
                                gap_pend_d = 1'b1;
                            end else begin
                                timer_d = timer_q - 32'd1;
                            end
                        end
                        GAP: begin
                            if (timer_q == 32'd0) begin
                                state_d     = SHOW;
                                timer_d     = show_len - 32'd1;
                                show_pend_d = 1'b1;
                            end else begin
                                timer_d = timer_q - 32'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // State, timer and registered outputs; asynchronous active-low reset
    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= 32'd0;
            show_pend_q  <= 1'b0;
            gap_pend_q   <= 1'b0;
            gen_active_q <= 1'b0;
            sym_valid_q  <= 1'b0;
            sym_code_q   <= 3'd0;
            sym_seg_q    <= SEG_BLANK;
            count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            show_pend_q  <= show_pend_d;
            gap_pend_q   <= gap_pend_d;
            gen_active_q <= gen_active_d;
            sym_valid_q  <= sym_valid_d;
            sym_code_q   <= sym_code_d;
            sym_seg_q    <= sym_seg_d;
            count_q      <= count_d;
        end
    end

    assign bus.genActive        = gen_active_q;
    assign bus.symValid         = sym_valid_q;
    assign bus.symCode          = sym_code_q;
    assign bus.symSeg           = sym_seg_q;
    assign bus.magicSymbolCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_symbol_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_symbol_generator
//  Description : Self-checking bench for symbol_generator. Two instances
//                (6 symbols and 4 symbols) are compared every cycle against
//                a schedule-based reference model, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_generator;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          GAP   = 2;
    localparam logic [2:0]  MAGIC = 3'd0;
    localparam logic [7:0]  TSEG [0:7] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    symbol_generator_if ifa ();
    symbol_generator_if ifb ();

    symbol_generator #(
        .NUM_SYMBOLS (6), .MAGIC_CODE (MAGIC), .GAP_CYCLES (32'd2), .SEED (SEED)
    ) dut_a (
        .Clk100M (clk), .reset (rst_n), .bus (ifa)
    );

    symbol_generator #(
        .NUM_SYMBOLS (4), .MAGIC_CODE (MAGIC), .GAP_CYCLES (32'd2), .SEED (SEED)
    ) dut_b (
        .Clk100M (clk), .reset (rst_n), .bus (ifb)
    );

    // ---------------- reference model (per instance) ----------------
    int          m_num [2] = '{6, 4};
    bit          m_run [2];
    int          m_t   [2];
    int          m_n   [2];
    int          m_p   [2];
    logic [15:0] m_lfsr[2];
    logic [2:0]  m_code[2];
    int          m_cnt [2];

    function automatic logic [15:0] sw_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_run[i] = 1'b0;
        m_t[i]   = 0;
        m_cnt[i] = 0;
        m_code[i] = 3'd0;
    endtask

    // Time since the start edge decides everything: t=0 LOAD, t=1 reseed,
    // from t=2 a new symbol every P cycles, shown N cycles then blank.
    task automatic model_edge(input int i, input logic start, input logic stop,
                              input logic [31:0] gmax, input logic [3:0] lvl);
        logic [15:0] s;
        logic [2:0]  low;
        if (m_run[i]) begin
            if (stop) begin
                m_run[i] = 1'b0;
            end else if (start) begin
                m_t[i] = 0;
            end else begin
                m_t[i]++;
                if (m_t[i] == 1) begin
                    s = SEED ^ {12'b0, lvl};
                    m_lfsr[i] = (s == 16'd0) ? SEED : s;
                    m_cnt[i]  = 0;
                    m_n[i]    = (gmax == 32'd0) ? 1 : int'(gmax);
                    m_p[i]    = m_n[i] + GAP;
                end else if ((m_t[i] - 2) % m_p[i] == 0) begin
                    m_lfsr[i] = sw_step(m_lfsr[i]);
                    low = m_lfsr[i][2:0];
                    if (int'(low) >= m_num[i]) m_code[i] = 3'(int'(low) - m_num[i]);
                    else                       m_code[i] = low;
                    if (m_code[i] == MAGIC && m_cnt[i] < 255) m_cnt[i]++;
                end
            end
        end else if (start && !stop) begin
            m_run[i] = 1'b1;
            m_t[i]   = 0;
        end
    endtask

    task automatic model_check(input int i, input logic ga, input logic sv,
                               input logic [2:0] sc, input logic [7:0] ss, input logic [7:0] mc);
        bit show;
        int ph;
        show = m_run[i] && (m_t[i] >= 2);
        ph   = show ? (m_t[i] - 2) % m_p[i] : 0;
        chk($sformatf("inst%0d genActive", i), 32'(ga), 32'(m_run[i]));
        chk($sformatf("inst%0d symValid", i), 32'(sv), 32'(show && ph == 0));
        chk($sformatf("inst%0d symSeg", i), 32'(ss),
            32'((show && ph < m_n[i]) ? TSEG[m_code[i]] : 8'hFF));
        chk($sformatf("inst%0d magicCount", i), 32'(mc), 32'(m_cnt[i]));
        if (show) chk($sformatf("inst%0d symCode", i), 32'(sc), 32'(m_code[i]));
    endtask

    // Compare process: advance the model on each edge, check just after it
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_edge(0, ifa.startGen, ifa.stopGen, ifa.symGenMax, ifa.curLevel);
            model_edge(1, ifb.startGen, ifb.stopGen, ifb.symGenMax, ifb.curLevel);
        end
        #1;
        model_check(0, ifa.genActive, ifa.symValid, ifa.symCode, ifa.symSeg, ifa.magicSymbolCount);
        model_check(1, ifb.genActive, ifb.symValid, ifb.symCode, ifb.symSeg, ifb.magicSymbolCount);
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic pulse_a(input logic st, input logic sp);
        @(posedge clk); #2;
        ifa.startGen = st; ifa.stopGen = sp;
        @(posedge clk); #2;
        ifa.startGen = 1'b0; ifa.stopGen = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vt[$];
        logic [2:0] vc[$];
        int nval;
        int nb;
        int first;
        int second;

        ifa.startGen = 1'b0; ifa.stopGen = 1'b0; ifa.symGenMax = 32'd4; ifa.curLevel = 4'd1;
        ifb.startGen = 1'b0; ifb.stopGen = 1'b0; ifb.symGenMax = 32'd1; ifb.curLevel = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("reset symSeg", 32'(ifa.symSeg), 32'hFF);
        chk("reset genActive", 32'(ifa.genActive), 32'd0);

        // First symbol two cycles after the start edge, then every 6 cycles
        ifa.startGen = 1'b1;
        @(posedge clk); #2;          // start edge k
        ifa.startGen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #2;
            if (ifa.symValid) begin
                vt.push_back(c);
                vc.push_back(ifa.symCode);
            end
            if (c == 2) chk("first symSeg", 32'(ifa.symSeg), 32'hF9);
        end
        if (vt.size() >= 3) begin
            chk("first valid offset", 32'(vt[0]), 32'd2);
            chk("second valid offset", 32'(vt[1]), 32'd8);
            chk("third valid offset", 32'(vt[2]), 32'd14);
            chk("first code", 32'(vc[0]), 32'd1);
            chk("second code", 32'(vc[1]), 32'd3);
            chk("third code", 32'(vc[2]), 32'd1);
        end else begin
            chk("valid pulses seen", 32'(vt.size()), 32'd3);
        end

        // Run to 50 symbols, stop, count held
        nval = vt.size();
        for (int c = 0; c < 600 && nval < 50; c++) begin
            @(posedge clk); #2;
            if (ifa.symValid) nval++;
        end
        chk("fifty symbols", 32'(nval), 32'd50);
        ifa.stopGen = 1'b1;
        @(posedge clk); #2;
        ifa.stopGen = 1'b0;
        chk("stop symSeg", 32'(ifa.symSeg), 32'hFF);
        chk("stop genActive", 32'(ifa.genActive), 32'd0);
        chk("stop magic count", 32'(ifa.magicSymbolCount), 32'(m_cnt[0]));
        repeat (10) @(posedge clk);
        #2;
        chk("held magic count", 32'(ifa.magicSymbolCount), 32'(m_cnt[0]));

        // start+stop together from IDLE
        pulse_a(1'b1, 1'b1);
        nval = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (ifa.symValid || ifa.genActive) nval++;
        end
        chk("start+stop idle activity", 32'(nval), 32'd0);

        // symGenMax = 0 behaves as 1
        ifa.symGenMax = 32'd0; ifa.curLevel = 4'd7;
        @(posedge clk); #2;
        ifa.startGen = 1'b1;
        @(posedge clk); #2;
        ifa.startGen = 1'b0;
        first = -1; second = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #2;
            if (ifa.symValid) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        chk("zero max first", 32'(first), 32'd2);
        chk("zero max period", 32'(second - first), 32'd3);

        // Reset mid-SHOW
        ifa.symGenMax = 32'd4;
        pulse_a(1'b1, 1'b0);
        for (int c = 0; c < 10 && !ifa.symValid; c++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async rst genActive", 32'(ifa.genActive), 32'd0);
        chk("async rst symValid", 32'(ifa.symValid), 32'd0);
        chk("async rst symCode", 32'(ifa.symCode), 32'd0);
        chk("async rst symSeg", 32'(ifa.symSeg), 32'hFF);
        chk("async rst count", 32'(ifa.magicSymbolCount), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("post reset idle", 32'(ifa.genActive), 32'd0);

        fork
            begin : b_saturate
                @(posedge clk); #2;
                ifb.startGen = 1'b1;
                @(posedge clk); #2;
                ifb.startGen = 1'b0;
                nb = 0;
                for (int c = 0; c < 6000 && nb < 1500; c++) begin
                    @(posedge clk); #2;
                    if (ifb.symValid) nb++;
                end
                chk("inst1 symbols", 32'(nb), 32'd1500);
                chk("inst1 saturated", 32'(ifb.magicSymbolCount), 32'd255);
                ifb.stopGen = 1'b1;
                @(posedge clk); #2;
                ifb.stopGen = 1'b0;
            end
            begin : a_random
                for (int r = 0; r < 40; r++) begin
                    @(posedge clk); #2;
                    ifa.symGenMax = $urandom_range(0, 5);
                    ifa.curLevel  = 4'($urandom_range(0, 15));
                    ifa.startGen  = 1'b1;
                    @(posedge clk); #2;
                    ifa.startGen  = 1'b0;
                    repeat ($urandom_range(3, 60)) @(posedge clk);
                    #2;
                    if ($urandom_range(0, 3) != 0) begin
                        ifa.stopGen = 1'b1;
                        @(posedge clk); #2;
                        ifa.stopGen = 1'b0;
                        repeat ($urandom_range(0, 4)) @(posedge clk);
                        #2;
                        if ($urandom_range(0, 1) == 1) begin
                            ifa.stopGen = 1'b1;
                            @(posedge clk); #2;
                            ifa.stopGen = 1'b0;
                        end
                    end
                end
                ifa.stopGen = 1'b1;
                @(posedge clk); #2;
                ifa.stopGen = 1'b0;
            end
        join

        repeat (4) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
